// File: rtl/parking_entry_conditioner.sv
// parking_entry_conditioner: sensor synchronise/debounce and two-digit keypad entry front-end
module parking_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       key_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pw_ready,
    output logic       pw_timeout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, GOT1, READY} state_t;

    state_t        state;
    logic [1:0]    ent_sync;
    logic [1:0]    exit_sync;
    logic [CW-1:0] ent_cnt;
    logic [CW-1:0] exit_cnt;
    logic [TW-1:0] timer;

    // two-flop synchronisers for both raw sensors
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_sync  <= '0;
            exit_sync <= '0;
        end else begin
            ent_sync  <= {ent_sync[0], raw_entrance};
            exit_sync <= {exit_sync[0], raw_exit};
        end
    end

    // entrance debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_cnt         <= '0;
            sensor_entrance <= 1'b0;
        end else if (ent_sync[1] == sensor_entrance) begin
            ent_cnt <= '0;
        end else if (ent_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            ent_cnt         <= '0;
            sensor_entrance <= ent_sync[1];
        end else begin
            ent_cnt <= ent_cnt + 1'b1;
        end
    end

    // exit debounce, identical behaviour to the entrance path
    always_ff @(posedge clk) begin
        if (reset) begin
            exit_cnt    <= '0;
            sensor_exit <= 1'b0;
        end else if (exit_sync[1] == sensor_exit) begin
            exit_cnt <= '0;
        end else if (exit_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            exit_cnt    <= '0;
            sensor_exit <= exit_sync[1];
        end else begin
            exit_cnt <= exit_cnt + 1'b1;
        end
    end

    // password entry FSM; abort beats a key, a key beats timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            password_1 <= '0;
            password_2 <= '0;
            pw_ready   <= 1'b0;
            pw_timeout <= 1'b0;
        end else begin
            pw_timeout <= 1'b0;
            if (state != IDLE && (key_clear || !sensor_entrance)) begin
                state      <= IDLE;
                password_1 <= '0;
                password_2 <= '0;
                pw_ready   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_valid && sensor_entrance) begin
                            password_1 <= key_digit;
                            timer      <= '0;
                            state      <= GOT1;
                        end
                    end
                    GOT1: begin
                        timer <= timer + 1'b1;
                        if (key_valid) begin
                            password_2 <= key_digit;
                            pw_ready   <= 1'b1;
                            state      <= READY;
                        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            password_1 <= '0;
                            pw_timeout <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_parking_entry_conditioner.sv
// tb_parking_entry_conditioner: directed plus random checks against a behavioural model
module tb_parking_entry_conditioner;
    localparam int D = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_entrance;
    logic       raw_exit;
    logic       key_valid;
    logic [1:0] key_digit;
    logic       key_clear;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pw_ready;
    logic       pw_timeout;

    parking_entry_conditioner #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset(reset),
        .raw_entrance(raw_entrance),
        .raw_exit(raw_exit),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .key_clear(key_clear),
        .sensor_entrance(sensor_entrance),
        .sensor_exit(sensor_exit),
        .password_1(password_1),
        .password_2(password_2),
        .pw_ready(pw_ready),
        .pw_timeout(pw_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: sync delay line, last D synced samples per sensor, entry progress
    int m_s1e, m_s2e, m_s1x, m_s2x;
    int he[D];
    int hx[D];
    int m_ent, m_ext;
    int m_digits, m_age, m_p1, m_p2, m_tout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit all_differ(input int h[D], input int o);
        foreach (h[i]) if (h[i] == o) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int se, sx, old_ent;
        m_tout = 0;
        if (reset) begin
            m_s1e = 0; m_s2e = 0; m_s1x = 0; m_s2x = 0;
            foreach (he[i]) begin he[i] = 0; hx[i] = 0; end
            m_ent = 0; m_ext = 0;
            m_digits = 0; m_age = 0; m_p1 = 0; m_p2 = 0;
        end else begin
            old_ent = m_ent;
            se = m_s2e; sx = m_s2x;
            m_s2e = m_s1e; m_s1e = int'(raw_entrance);
            m_s2x = m_s1x; m_s1x = int'(raw_exit);
            for (int i = D - 1; i > 0; i--) begin he[i] = he[i-1]; hx[i] = hx[i-1]; end
            he[0] = se; hx[0] = sx;
            if (all_differ(he, m_ent)) m_ent = se;
            if (all_differ(hx, m_ext)) m_ext = sx;
            if (m_digits > 0 && (key_clear || old_ent == 0)) begin
                m_digits = 0; m_p1 = 0; m_p2 = 0;
            end else if (m_digits == 0) begin
                if (key_valid && old_ent == 1) begin
                    m_p1 = int'(key_digit); m_digits = 1; m_age = 0;
                end
            end else if (m_digits == 1) begin
                m_age++;
                if (key_valid) begin
                    m_p2 = int'(key_digit); m_digits = 2;
                end else if (m_age == T) begin
                    m_p1 = 0; m_digits = 0; m_tout = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("sensor_entrance", sensor_entrance, m_ent);
        check("sensor_exit", sensor_exit, m_ext);
        check("password_1", password_1, m_p1);
        check("password_2", password_2, m_p2);
        check("pw_ready", pw_ready, m_digits == 2);
        check("pw_timeout", pw_timeout, m_tout);
    endtask

    task automatic press(input logic [1:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
        key_digit = 2'b00;
    endtask

    initial begin
        int fe, fx, fk;
        reset = 1'b1; raw_entrance = 1'b0; raw_exit = 1'b0;
        key_valid = 1'b0; key_digit = 2'b00; key_clear = 1'b0;
        tick(); tick();
        check("rst_ready", pw_ready, 0);
        check("rst_p1", password_1, 0);
        reset = 1'b0;
        repeat (5) tick();
        raw_entrance = 1'b1;
        tick();
        repeat (4) tick();
        check("deb_early", sensor_entrance, 0);
        tick();
        check("deb_on", sensor_entrance, 1);
        raw_exit = 1'b1;
        repeat (3) tick();
        raw_exit = 1'b0;
        repeat (8) tick();
        check("glitch_exit", sensor_exit, 0);
        press(2'b01); tick(); tick(); press(2'b10);
        check("cap_ready", pw_ready, 1);
        check("cap_p1", password_1, 2'b01);
        check("cap_p2", password_2, 2'b10);
        key_clear = 1'b1; tick(); key_clear = 1'b0;
        check("clear_ready", pw_ready, 0);
        press(2'b11);
        repeat (T - 1) tick();
        check("to_early", pw_timeout, 0);
        tick();
        check("to_pulse", pw_timeout, 1);
        check("to_p1", password_1, 0);
        tick();
        check("to_one_cycle", pw_timeout, 0);
        press(2'b11);
        repeat (T - 1) tick();
        press(2'b00);
        check("edge_key_ready", pw_ready, 1);
        check("edge_key_no_to", pw_timeout, 0);
        raw_entrance = 1'b0;
        tick();
        repeat (4) tick();
        check("fall_early", sensor_entrance, 1);
        tick();
        check("fall_deb", sensor_entrance, 0);
        check("fall_still_ready", pw_ready, 1);
        tick();
        check("fall_abort", pw_ready, 0);
        check("fall_p1", password_1, 0);
        press(2'b10);
        check("gate_p1", password_1, 0);
        raw_entrance = 1'b1;
        repeat (7) tick();
        press(2'b01);
        key_clear = 1'b1; key_valid = 1'b1; key_digit = 2'b11;
        tick();
        key_clear = 1'b0; key_valid = 1'b0; key_digit = 2'b00;
        check("clrkey_p1", password_1, 0);
        check("clrkey_ready", pw_ready, 0);
        press(2'b10);
        raw_exit = 1'b1;
        repeat (3) tick();
        check("pre_rst_p1", password_1, 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0; raw_exit = 1'b0;
        check("mid_rst_p1", password_1, 0);
        check("mid_rst_to", pw_timeout, 0);
        check("mid_rst_ent", sensor_entrance, 0);
        repeat (8) tick();
        press(2'b01); press(2'b11);
        check("post_rst_ready", pw_ready, 1);
        check("post_rst_p2", password_2, 2'b11);
        for (int c = 0; c < 4000; c++) begin
            fe = ((c / 400) % 2 == 0) ? 6 : 60;
            fx = ((c / 250) % 2 == 0) ? 4 : 30;
            fk = ((c / 300) % 2 == 0) ? 3 : 40;
            if ($urandom_range(fe - 1) == 0) raw_entrance = ~raw_entrance;
            if ($urandom_range(fx - 1) == 0) raw_exit = ~raw_exit;
            key_valid = ($urandom_range(fk - 1) == 0);
            key_digit = 2'($urandom_range(3));
            key_clear = ($urandom_range(39) == 0);
            reset     = ($urandom_range(599) == 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_entry_conditioner.md
Name: parking_entry_conditioner

Overview:
- Upstream front-end for the parking controller.
- Synchronises and debounces the raw entrance and exit sensor inputs, producing the clean sensor_entrance and sensor_exit levels.
- Assembles two keypad digit strobes into the password_1 and password_2 pair, with a ready flag, an inactivity timeout and abort handling.
- Every output drives the controller's inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must differ from the output before the output flips (must be 2 or more).
- TIMEOUT_CYCLES, 1000, cycles allowed between digit 1 and digit 2 before entry is abandoned (must be 2 or more).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- raw_entrance  in  1  asynchronous entrance sensor.
- raw_exit  in  1  asynchronous exit sensor.
- key_valid  in  1  one-cycle strobe; key_digit is valid in that cycle.
- key_digit  in  2  keypad digit value.
- key_clear  in  1  one-cycle strobe; discards the current entry.
- sensor_entrance  out  1  debounced entrance level.
- sensor_exit  out  1  debounced exit level.
- password_1  out  2  first captured digit.
- password_2  out  2  second captured digit.
- pw_ready  out  1  high while both digits are held.
- pw_timeout  out  1  one-cycle pulse when an entry is abandoned by timeout.

Behaviour:
- Reset: synchronous and active-high, dominates everything else.
  - Sync flops, debounce counters and timer go to 0; FSM goes to IDLE.
  - All outputs are 0 from the first edge on which reset is sampled high.
  - Reset asserted mid-entry discards the entry; no pw_timeout pulse is generated.
- Synchroniser: a 2-flop chain per raw input.
- Debounce, independently per sensor:
  - On each edge, if the sync output differs from the debounced output, the counter increments; otherwise it clears.
  - When the counter would reach DEBOUNCE_CYCLES, the output takes the sync value and the counter clears.
  - Latency: raw first sampled at edge k, output changes at edge k+1+DEBOUNCE_CYCLES.
  - Pulses or glitches shorter than DEBOUNCE_CYCLES cycles, measured at the sync output, never reach the output.
- Password FSM states: IDLE, GOT1, READY.
- IDLE:
  - key_valid with sensor_entrance=1: password_1 <= key_digit, timer <= 0, go to GOT1.
  - key_valid with sensor_entrance=0: ignored.
- GOT1:
  - Timer increments every cycle.
  - key_valid: password_2 <= key_digit, go to READY, pw_ready=1 from the next cycle.
  - If no key_valid has arrived, at the TIMEOUT_CYCLES-th edge after the digit-1 capture: clear both passwords, pw_timeout=1 for exactly one cycle, go to IDLE.
  - key_valid on the expiry edge wins over timeout.
- READY:
  - Holds both passwords and pw_ready=1.
  - key_valid is ignored; there is no timeout.
- Abort, in GOT1 or READY:
  - Triggered by key_clear, or by sensor_entrance falling (debounced, i.e. the car has passed or backed off).
  - Clears both passwords and pw_ready, goes to IDLE, no pw_timeout.
  - key_clear beats key_valid in the same cycle.
  - key_clear in IDLE has no effect.
- Priority, highest first: reset, abort, key_valid, timeout.
- password_2 is 0 whenever the FSM is not in READY; password_1 is 0 in IDLE.
- sensor_exit has no effect on the FSM.
- Outputs are registered, with no combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16):
1. Debounce:
   - raw_entrance 0 to 1, first sampled at edge 10 and held → sensor_entrance=1 after edge 15, not before.
   - 3-cycle high glitch on raw_exit → sensor_exit stays 0.
2. Password capture: sensor_entrance=1; key 2'b01, then key 2'b10 three cycles later → password_1=01, password_2=10, pw_ready=1 the cycle after the second key, pw_timeout never asserted.
3. Timeout:
   - Key 2'b11, then no key for 16 cycles → one-cycle pw_timeout; password_1=00, pw_ready=0, FSM in IDLE.
   - A repeat with the second key on exactly the 16th edge → READY, no timeout.
4. Gating: key_valid while sensor_entrance=0 → no state change, all password outputs remain 00.
5. Abort:
   - In READY, raw_entrance falls → 5 edges later sensor_entrance=0 and, one edge after that, pw_ready=0 with passwords 00.
   - key_clear and key_valid together in GOT1 → IDLE, passwords 00.
6. Reset: assert reset in GOT1 with password_1=10 and a partial debounce count → all outputs 0 at the next edge, no pw_timeout; normal entry works after release.
